// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and counter sizing shared by the alu_seq slice
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_MULTU = 4'd3;
    localparam logic [3:0] ALU_DIVU  = 4'd4;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_MFHI  = 4'd10;
    localparam logic [3:0] ALU_MFLO  = 4'd11;
    localparam logic [3:0] ALU_NOR   = 4'd12;
    typedef enum logic {S_IDLE, S_BUSY} state_e;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between operand muxing, alu_seq and writeback
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output in_valid, alu_ctl, a, b,
                    input  in_ready, out_valid, result, zero, overflow, hi, lo);
    modport slave  (input  in_valid, alu_ctl, a, b,
                    output in_ready, out_valid, result, zero, overflow, hi, lo);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = cnt_w(WIDTH);
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d, step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     ms, sh, df;
    always_comb begin
        ms     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        df     = sh - {1'b0, opnd_q};
        step   = div_q ? {df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0], acc_q[WIDTH-2:0], ~df[WIDTH]}
                       : {ms, acc_q[WIDTH-1:1]};
        acc_d  = start_i ? {{WIDTH{1'b0}}, div_i ? a_i : b_i} : (cnt_q != '0 ? step : acc_q);
        opnd_d = start_i ? (div_i ? b_i : a_i) : opnd_q;
        div_d  = start_i ? div_i : div_q;
        cnt_d  = start_i ? CW'(WIDTH) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end
    // the final iteration's result is handed out combinationally for the top to latch
    assign done_o = cnt_q == CW'(1);
    assign hi_o   = step[2*WIDTH-1:WIDTH];
    assign lo_o   = step[WIDTH-1:0];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered single-cycle ALU with an iterative MULTU/DIVU engine feeding HI/LO
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_seq_if.slave   bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] sum, dif, res_c, md_hi, md_lo;
    logic             out_valid_q, out_valid_d, overflow_q, overflow_d;
    logic             ov_c, accept, is_iter, single, start, done, fin;
    logic [3:0]       ctl;
    assign ctl     = bus.alu_ctl;
    assign accept  = bus.in_valid & (state_q == S_IDLE);
    assign is_iter = ctl == ALU_MULTU || ctl == ALU_DIVU;
    assign start   = accept & is_iter;
    assign single  = accept & ~is_iter;
    assign fin     = (state_q == S_BUSY) & done;
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .div_i   (ctl == ALU_DIVU),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .done_o  (done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );
    always_comb begin
        sum   = bus.a + bus.b;
        dif   = bus.a - bus.b;
        res_c = ctl == ALU_AND  ? bus.a & bus.b :
                ctl == ALU_OR   ? bus.a | bus.b :
                ctl == ALU_ADD  ? sum :
                ctl == ALU_SUB  ? dif :
                ctl == ALU_SLT  ? {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)} :
                ctl == ALU_SLTU ? {{(WIDTH-1){1'b0}}, bus.a < bus.b} :
                ctl == ALU_NOR  ? ~(bus.a | bus.b) :
                ctl == ALU_MFHI ? hi_q :
                ctl == ALU_MFLO ? lo_q : '0;
        ov_c  = ctl == ALU_ADD ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]) :
                ctl == ALU_SUB ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (dif[WIDTH-1] != bus.a[WIDTH-1]) :
                1'b0;
        state_d     = state_q == S_IDLE ? (start ? S_BUSY : S_IDLE) : (done ? S_IDLE : S_BUSY);
        out_valid_d = single | fin;
        result_d    = single ? res_c : fin ? md_lo : result_q;
        overflow_d  = single ? ov_c : fin ? 1'b0 : overflow_q;
        hi_d        = fin ? md_hi : hi_q;
        lo_d        = fin ? md_lo : lo_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end
    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = result_q == '0;
    assign bus.overflow  = overflow_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for iterative ops, 32- and 8-bit instances
module tb_alu_seq;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    alu_seq_if #(.WIDTH(32)) b32 ();
    alu_seq_if #(.WIDTH(8))  b8 ();
    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
    } vec_t;
    vec_t v[14];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive32(input logic vld, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        b32.in_valid = vld;
        b32.alu_ctl  = ctl;
        b32.a        = a;
        b32.b        = b;
    endtask
    task automatic run_iter(input string nm, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic [3:0] nctl, input logic [31:0] na, input logic [31:0] nb,
                            input logic [31:0] nres);
        int lat;
        int busy;
        @(negedge clk);
        drive32(1'b1, ctl, a, b);
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!b32.in_ready) busy++;
            if (lat == 1) drive32(1'b1, nctl, na, nb);
        end while (!b32.out_valid && lat < 100);
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " busy cycles"}, 64'(busy), 64'd32);
        chk({nm, " hi"}, b32.hi, ehi);
        chk({nm, " lo"}, b32.lo, elo);
        chk({nm, " result"}, b32.result, elo);
        chk({nm, " zero"}, b32.zero, elo == 0);
        chk({nm, " overflow"}, b32.overflow, 0);
        chk({nm, " ready at done"}, b32.in_ready, 1);
        @(negedge clk);
        b32.in_valid = 1'b0;
        chk({nm, " follow valid"}, b32.out_valid, 1);
        chk({nm, " follow result"}, b32.result, nres);
    endtask
    initial begin
        int lat;
        int busy;
        int pulses;
        v[0]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        v[1]  = '{ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0};
        v[2]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        v[3]  = '{ALU_ADD,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0};
        v[4]  = '{ALU_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        v[5]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
        v[6]  = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        v[7]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        v[8]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        v[9]  = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        v[10] = '{ALU_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0};
        v[11] = '{4'd5,     32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0};
        v[12] = '{4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        v[13] = '{ALU_MFHI, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        drive32(1'b1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        b8.in_valid = 1'b0;
        b8.alu_ctl  = ALU_AND;
        b8.a        = '0;
        b8.b        = '0;
        @(negedge clk);
        chk("rst result", b32.result, 0);
        chk("rst zero", b32.zero, 1);
        chk("rst out_valid", b32.out_valid, 0);
        chk("rst overflow", b32.overflow, 0);
        chk("rst hi", b32.hi, 0);
        chk("rst lo", b32.lo, 0);
        chk("rst in_ready", b32.in_ready, 1);
        b32.in_valid = 1'b0;
        rst_n = 1'b1;
        // one vector accepted per cycle; each result is checked the cycle after its accept
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("vec%0d result", i - 1), b32.result, v[i-1].res);
                chk($sformatf("vec%0d overflow", i - 1), b32.overflow, v[i-1].ov);
                chk($sformatf("vec%0d zero", i - 1), b32.zero, v[i-1].res == 0);
                chk($sformatf("vec%0d out_valid", i - 1), b32.out_valid, 1);
                chk($sformatf("vec%0d in_ready", i - 1), b32.in_ready, 1);
            end
            if (i < 14) drive32(1'b1, v[i].ctl, v[i].a, v[i].b);
            else b32.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("idle out_valid", b32.out_valid, 0);
        chk("idle result hold", b32.result, 0);
        run_iter("multu max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                 ALU_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFE);
        run_iter("multu shift", ALU_MULTU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000,
                 ALU_MFHI, 32'h0, 32'h0, 32'h0000_0003);
        run_iter("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
                 ALU_ADD, 32'd1, 32'd2, 32'd3);
        run_iter("divu big", ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF,
                 ALU_MFLO, 32'h0, 32'h0, 32'h0FFF_FFFF);
        run_iter("divu by 0", ALU_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF,
                 ALU_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        drive32(1'b1, ALU_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst hi", b32.hi, 0);
        chk("midrst lo", b32.lo, 0);
        chk("midrst result", b32.result, 0);
        chk("midrst in_ready", b32.in_ready, 1);
        chk("midrst out_valid", b32.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (b32.out_valid) pulses++;
        end
        chk("midrst no pulse", 64'(pulses), 0);
        chk("midrst hi after", b32.hi, 0);
        chk("midrst lo after", b32.lo, 0);
        b8.in_valid = 1'b1;
        b8.alu_ctl  = ALU_MULTU;
        b8.a        = 8'hFF;
        b8.b        = 8'hFF;
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!b8.in_ready) busy++;
            if (lat == 1) begin
                b8.alu_ctl = ALU_ADD;
                b8.a       = 8'h7F;
                b8.b       = 8'h01;
            end
        end while (!b8.out_valid && lat < 100);
        chk("w8 multu latency", 64'(lat), 9);
        chk("w8 multu busy", 64'(busy), 8);
        chk("w8 multu hi", b8.hi, 8'hFE);
        chk("w8 multu lo", b8.lo, 8'h01);
        chk("w8 multu result", b8.result, 8'h01);
        @(negedge clk);
        b8.in_valid = 1'b0;
        chk("w8 add result", b8.result, 8'h80);
        chk("w8 add overflow", b8.overflow, 1);
        chk("w8 add valid", b8.out_valid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's single-cycle combinational ALU. Keeps the single-cycle logic/arithmetic ops with a registered output, and adds an iterative unsigned multiply/divide engine that writes architectural HI/LO registers. Sits in the execute stage between operand muxing and writeback. Throughout this spec, "ready" means the `in_ready` port.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; must be ≥ 4.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept; accept = `in_valid & in_ready`.
- `alu_ctl`  in  4  operation code.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  one-cycle pulse: `result` is new.
- `result`  out  WIDTH  registered result; holds between pulses.
- `zero`  out  1  `result == 0`, derived from the registered `result`.
- `overflow`  out  1  signed overflow of the last ADD/SUB; 0 for every other op.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- Single-cycle codes:
  - 0: AND
  - 1: OR
  - 2: ADD
  - 6: SUB
  - 7: SLT, signed, result 1/0
  - 8: SLTU, unsigned
  - 12: NOR
  - 10: MFHI, result = `hi`
  - 11: MFLO, result = `lo`
- Any other code not listed here: result 0, `out_valid` still pulses.
- Iterative codes:
  - 3: MULTU. Shift-add, one bit per cycle. {hi,lo} = a*b, full 2*WIDTH product.
  - 4: DIVU. Restoring, one quotient bit per cycle. lo = a/b, hi = a%b.
- For an iterative op, `result` = the new `lo` value.
- DIVU by zero runs the full iteration and must produce lo = all ones, hi = a. It raises no flag.
- ADD/SUB wrap modulo 2^WIDTH.
- `overflow` = the operands' sign bits agree (for SUB: a's sign and ~b's sign agree) and the result sign differs from them.
- `hi`/`lo` change only on completion of an iterative op, or on reset.
- State machine: IDLE, BUSY.
  - IDLE: `in_ready` = 1. On accepting an iterative op, capture the operands, load the counter with WIDTH, and go to BUSY.
  - IDLE: on accepting a single-cycle op, register the result and stay in IDLE.
  - BUSY: `in_ready` = 0. One iteration per cycle; the counter decrements.
  - BUSY: after the iteration with counter == 1, write hi/lo/result, pulse `out_valid`, and return to IDLE.
- `in_valid` while BUSY is ignored. The requester must hold its request.
- There is no output backpressure. The consumer must take `out_valid` when it pulses.

## Timing
- Reset values, applied asynchronously:
  - `result`, `hi`, `lo` = 0
  - `out_valid`, `overflow` = 0
  - `zero` = 1
  - state = IDLE, `in_ready` = 1, counter = 0
- Single-cycle op accepted in cycle T: `out_valid`/`result` visible in T+1.
  - Back-to-back accepts give one result per cycle.
- Iterative op accepted in T:
  - `in_ready` = 0 for cycles T+1 .. T+WIDTH.
  - `out_valid`, `result`, `hi`, `lo` are updated and `in_ready` = 1 in cycle T+WIDTH+1. A new op may be accepted in that same cycle.
- MFHI/MFLO accepted in the completion cycle T+WIDTH+1 returns the new hi/lo.
- Reset asserted mid-BUSY: abandon the op and apply reset values; no `out_valid` pulse.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams: `ALU_AND` … `ALU_DIVU`
  - the state enum `{S_IDLE, S_BUSY}`
  - a width function for the counter: $clog2(WIDTH+1).
- Sub-module `alu_muldiv_iter`:
  - holds the operand, partial-product/remainder registers and the counter.
  - interface: start/op/a/b in; done/hi/lo out.
- Top level holds the combinational single-cycle datapath, the FSM and the output registers.

## Test plan
- Reset with `in_valid` = 1: outputs at reset values, `zero` = 1. After release, AND 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000 with `out_valid` at T+1.
- ADD 0x7FFF_FFFF + 1 → 0x8000_0000 with `overflow` = 1. SUB 5-5 → 0 with `zero` = 1. SLT -1 < 1 → 1 and SLTU 0xFFFF_FFFF < 1 → 0, issued back-to-back, one result per cycle.
- MULTU 0xFFFF_FFFF * 0xFFFF_FFFF → hi = 0xFFFF_FFFE, lo = 0x0000_0001. `in_ready` low for exactly 32 cycles, `out_valid` at T+33. A MFHI issued in T+33 returns 0xFFFF_FFFE.
- DIVU 100/7 → lo = 14, hi = 2. DIVU 9/0 → lo = 0xFFFF_FFFF, hi = 9.
- `in_valid` held with a different op during BUSY is not accepted until T+33. Asserting `rst_n` low at T+10 clears hi/lo to 0 and produces no `out_valid`.
- Repeat with WIDTH = 8: MULTU 0xFF*0xFF → hi = 0xFE, lo = 0x01, `out_valid` at T+9.
